// File: rtl/ctrl_pkg.sv
// Shared encodings for the control unit: condition codes, opcodes, ALU controls, FSM states.
// Pure declarations; no logic, no latency.
package ctrl_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  typedef enum logic [1:0] {
    OP_DP   = 2'b00,
    OP_MEM  = 2'b01,
    OP_BR   = 2'b10,
    OP_NONE = 2'b11
  } op_e;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic [1:0] reg_src;
    logic [1:0] imm_src;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       alu_op;
  } dec_t;

endpackage

// File: rtl/control_unit_if.sv
// Bundle between control unit and datapath/memory: instruction and status in, controls out.
// Wires only; master is the control unit, slave is the datapath side.
interface control_unit_if;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        MemReady;
  logic [1:0]  RegSrc;
  logic        RegWrite;
  logic [1:0]  ImmSrc;
  logic        ALUSrc;
  logic [1:0]  ALUControl;
  logic        MemtoReg;
  logic        PCSrc;
  logic        MemWrite;
  logic        MemReq;
  logic        PCWrite;
  logic        MemErr;

  modport master (
    input  Instr, ALUFlags, MemReady,
    output RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl, MemtoReg,
           PCSrc, MemWrite, MemReq, PCWrite, MemErr
  );

  modport slave (
    output Instr, ALUFlags, MemReady,
    input  RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl, MemtoReg,
           PCSrc, MemWrite, MemReq, PCWrite, MemErr
  );
endinterface

// File: rtl/cond_logic.sv
// NZCV flag register and condition evaluation against the stored flags.
// CondEx is combinational from stored flags; flags update at the clock edge, no backpressure.
module cond_logic
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_w,
  input  logic       en,
  output logic       cond_ex
);

  logic n, z, c, v;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n <= 1'b0;
      z <= 1'b0;
      c <= 1'b0;
      v <= 1'b0;
    end else begin
      if (en && cond_ex && flag_w[1]) begin
        n <= alu_flags[3];
        z <= alu_flags[2];
      end
      if (en && cond_ex && flag_w[0]) begin
        c <= alu_flags[1];
        v <= alu_flags[0];
      end
    end
  end

  always_comb begin
    cond_ex = 1'b0;
    case (cond_e'(cond))
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = !z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = !c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = !n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = !v;
      COND_HI: cond_ex = c && !z;
      COND_LS: cond_ex = !c || z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = !z && (n == v);
      COND_LE: cond_ex = z || (n != v);
      COND_AL: cond_ex = 1'b1;
      COND_NV: cond_ex = 1'b0;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Single-cycle ARM-subset controller with a RUN/WAIT stall FSM for slow data memory.
// Controls are combinational; a pending load/store holds PCWrite low until MemReady or timeout.
module control_unit
  import ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 15
) (
  input  logic           clk,
  input  logic           reset,
  control_unit_if.master cu
);

  localparam int CW = $clog2(WAIT_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);

  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] cmd;
  logic [3:0] rd;
  logic       unused_instr;

  assign op    = cu.Instr[27:26];
  assign funct = cu.Instr[25:20];
  assign cmd   = funct[4:1];
  assign rd    = cu.Instr[15:12];
  assign unused_instr = ^{cu.Instr[19:16], cu.Instr[11:0]};

  dec_t       dec;
  logic [1:0] alu_ctl;
  logic       reg_w;
  logic [1:0] flag_w;
  logic       pcs;

  always_comb begin
    dec = '0;
    case (op_e'(op))
      OP_DP: begin
        dec.alu_src = funct[5];
        dec.reg_w   = 1'b1;
        dec.alu_op  = 1'b1;
      end
      OP_MEM: begin
        dec.imm_src = 2'b01;
        dec.alu_src = 1'b1;
        if (funct[0]) begin
          dec.mem_to_reg = 1'b1;
          dec.reg_w      = 1'b1;
        end else begin
          dec.reg_src = 2'b10;
          dec.mem_w   = 1'b1;
        end
      end
      OP_BR: begin
        dec.reg_src = 2'b01;
        dec.imm_src = 2'b10;
        dec.alu_src = 1'b1;
        dec.branch  = 1'b1;
      end
      default: dec = '0;
    endcase
  end

  // Unsupported data-processing commands fall back to ADD but never write back.
  always_comb begin
    alu_ctl = ALU_ADD;
    reg_w   = dec.reg_w;
    if (dec.alu_op) begin
      case (cmd)
        CMD_ADD: alu_ctl = ALU_ADD;
        CMD_SUB: alu_ctl = ALU_SUB;
        CMD_AND: alu_ctl = ALU_AND;
        CMD_ORR: alu_ctl = ALU_ORR;
        default: reg_w   = 1'b0;
      endcase
    end
  end

  assign flag_w[1] = dec.alu_op & funct[0];
  assign flag_w[0] = flag_w[1] & ((cmd == CMD_ADD) | (cmd == CMD_SUB));
  assign pcs       = dec.branch | (reg_w & (rd == 4'hF));

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          skip_q, skip_d;
  logic          err_q, err_d;
  logic          cond_ex, run_ok, exec, is_mem, mem_req, pending, timeout, done;

  cond_logic u_cond (
    .clk      (clk),
    .reset    (reset),
    .cond     (cu.Instr[31:28]),
    .alu_flags(cu.ALUFlags),
    .flag_w   (flag_w),
    .en       (run_ok),
    .cond_ex  (cond_ex)
  );

  // skip_q marks the single cycle after a timeout: the stalled instruction is dropped.
  assign run_ok  = (state_q == RUN) && !skip_q;
  assign exec    = (state_q == WAIT) || (run_ok && cond_ex);
  assign is_mem  = dec.mem_w | dec.mem_to_reg;
  assign mem_req = reset && exec && is_mem;
  assign pending = mem_req && !cu.MemReady;
  assign cnt_inc = cnt_q + CW'(1);
  assign timeout = pending && (cnt_inc == LIMIT);
  assign done    = reset && exec && (!is_mem || cu.MemReady);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      skip_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      skip_q  <= skip_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    skip_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      RUN: begin
        cnt_d = '0;
        if (timeout) begin
          skip_d = 1'b1;
          err_d  = 1'b1;
        end else if (pending) begin
          state_d = WAIT;
          cnt_d   = cnt_inc;
        end
      end
      WAIT: begin
        if (timeout) begin
          state_d = RUN;
          cnt_d   = '0;
          skip_d  = 1'b1;
          err_d   = 1'b1;
        end else if (pending) begin
          cnt_d = cnt_inc;
        end else begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  assign cu.RegSrc     = dec.reg_src;
  assign cu.ImmSrc     = dec.imm_src;
  assign cu.ALUSrc     = dec.alu_src;
  assign cu.ALUControl = alu_ctl;
  assign cu.MemtoReg   = dec.mem_to_reg;
  assign cu.RegWrite   = done && reg_w;
  assign cu.PCSrc      = done && pcs;
  assign cu.MemReq     = mem_req;
  assign cu.MemWrite   = mem_req && dec.mem_w;
  assign cu.PCWrite    = reset && !pending;
  assign cu.MemErr     = err_q;

endmodule
